// File: rtl/wash_cycle_ctrl.sv
// Washing-machine cycle sequencer: SOAK -> WASH (xN passes) -> RINSE -> SPIN -> DONE.
// Define WASH_PAUSE_EN to compile in pause_i support (freezes timed phases).
module wash_cycle_ctrl #(
  parameter int unsigned SOAK_T   = 3,
  parameter int unsigned WASH_T   = 3,
  parameter int unsigned RINSE_T  = 3,
  parameter int unsigned SPIN_T   = 3,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MAX_WASH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [2:0] wash_cnt_i,
  input  logic       pause_i,
  input  logic       abort_i,
  output logic [2:0] phase_o,
  output logic [2:0] wash_pass_o,
  output logic       busy_o,
  output logic       door_lock_o,
  output logic       done_o,
  output logic       abort_o
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSoak  = 3'd1,
    StWash  = 3'd2,
    StRinse = 3'd3,
    StSpin  = 3'd4,
    StDone  = 3'd5,
    StAbort = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] SoakLast  = CNT_W'(SOAK_T - 1);
  localparam logic [CNT_W-1:0] WashLast  = CNT_W'(WASH_T - 1);
  localparam logic [CNT_W-1:0] RinseLast = CNT_W'(RINSE_T - 1);
  localparam logic [CNT_W-1:0] SpinLast  = CNT_W'(SPIN_T - 1);
  localparam logic [2:0]       MaxPass   = 3'(MAX_WASH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       pass_q, pass_d;
  logic [2:0]       passes_q, passes_d;
  logic [2:0]       passes_clamped;
  logic [CNT_W-1:0] last;
  logic             hold;

`ifdef WASH_PAUSE_EN
  assign hold = pause_i;
`else
  logic unused_pause;
  assign hold         = 1'b0;
  assign unused_pause = pause_i;
`endif

  always_comb begin
    if (wash_cnt_i == 3'd0) begin
      passes_clamped = 3'd1;
    end else if (wash_cnt_i > MaxPass) begin
      passes_clamped = MaxPass;
    end else begin
      passes_clamped = wash_cnt_i;
    end
  end

  always_comb begin
    case (state_q)
      StSoak:  last = SoakLast;
      StWash:  last = WashLast;
      StRinse: last = RinseLast;
      default: last = SpinLast;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    pass_d   = pass_q;
    passes_d = passes_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StSoak;
          timer_d  = '0;
          pass_d   = '0;
          passes_d = passes_clamped;
        end
      end
      StSoak, StWash, StRinse, StSpin: begin
        // abort beats pause, pause beats expiry
        if (abort_i) begin
          state_d = StAbort;
          timer_d = '0;
        end else if (!hold) begin
          if (timer_q == last) begin
            timer_d = '0;
            case (state_q)
              StSoak: begin
                state_d = StWash;
                pass_d  = 3'd1;
              end
              StWash: begin
                if (pass_q < passes_q) begin
                  pass_d = pass_q + 3'd1;
                end else begin
                  state_d = StRinse;
                end
              end
              StRinse: state_d = StSpin;
              default: state_d = StDone;
            endcase
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      end
      StDone, StAbort: begin
        state_d = StIdle;
        pass_d  = '0;
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
        pass_d  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      pass_q      <= '0;
      passes_q    <= '0;
      phase_o     <= '0;
      wash_pass_o <= '0;
      busy_o      <= 1'b0;
      door_lock_o <= 1'b0;
      done_o      <= 1'b0;
      abort_o     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pass_q      <= pass_d;
      passes_q    <= passes_d;
      phase_o     <= state_d;
      wash_pass_o <= (state_d == StWash) ? pass_d : 3'd0;
      busy_o      <= (state_d inside {StSoak, StWash, StRinse, StSpin});
      door_lock_o <= (state_d inside {StSoak, StWash, StRinse, StSpin, StDone});
      done_o      <= (state_d == StDone);
      abort_o     <= (state_d == StAbort);
    end
  end

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Randomized scoreboard bench for wash_cycle_ctrl: driver pushes per-cycle expectations
// from a phase-list model, monitor pops and compares after every clock edge.
module tb_wash_cycle_ctrl;

  localparam int unsigned SoakT   = 2;
  localparam int unsigned WashT   = 3;
  localparam int unsigned RinseT  = 4;
  localparam int unsigned SpinT   = 5;
  localparam int unsigned MaxWash = 4;

`ifdef WASH_PAUSE_EN
  localparam bit PauseOn = 1'b1;
`else
  localparam bit PauseOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i, pause_i, abort_i;
  logic [2:0] wash_cnt_i;
  logic [2:0] phase_o, wash_pass_o;
  logic       busy_o, door_lock_o, done_o, abort_o;

  typedef struct packed {
    logic [2:0] ph;
    logic [2:0] ps;
  } rec_t;

  rec_t exp_q[$];
  rec_t plan[$];
  rec_t mon_r;
  rec_t cur;
  int   n_checks = 0;
  int   n_pass   = 0;

  wash_cycle_ctrl #(
    .SOAK_T  (SoakT),
    .WASH_T  (WashT),
    .RINSE_T (RinseT),
    .SPIN_T  (SpinT),
    .CNT_W   (8),
    .MAX_WASH(MaxWash)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .wash_cnt_i (wash_cnt_i),
    .pause_i    (pause_i),
    .abort_i    (abort_i),
    .phase_o    (phase_o),
    .wash_pass_o(wash_pass_o),
    .busy_o     (busy_o),
    .door_lock_o(door_lock_o),
    .done_o     (done_o),
    .abort_o    (abort_o)
  );

  always #5 clk = ~clk;

  function automatic rec_t mk(input int ph, input int ps);
    rec_t r;
    r.ph = 3'(ph);
    r.ps = 3'(ps);
    return r;
  endfunction

  function automatic bit timed(input rec_t r);
    return (r.ph >= 3'd1) && (r.ph <= 3'd4);
  endfunction

  function automatic logic [31:0] expv(input rec_t r);
    logic busy, lock, done, ab;
    busy = timed(r);
    lock = busy || (r.ph == 3'd5);
    done = (r.ph == 3'd5);
    ab   = (r.ph == 3'd6);
    return {22'b0, r.ph, r.ps, busy, lock, done, ab};
  endfunction

  function automatic logic [31:0] outs();
    return {22'b0, phase_o, wash_pass_o, busy_o, door_lock_o, done_o, abort_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Whole-cycle phase list for one run, as seen after each clock edge.
  task automatic build_plan(input int w);
    int n;
    n = (w == 0) ? 1 : ((w > int'(MaxWash)) ? int'(MaxWash) : w);
    plan.delete();
    repeat (SoakT) plan.push_back(mk(1, 0));
    for (int p = 1; p <= n; p++) repeat (WashT) plan.push_back(mk(2, p));
    repeat (RinseT) plan.push_back(mk(3, 0));
    repeat (SpinT) plan.push_back(mk(4, 0));
    plan.push_back(mk(5, 0));
    plan.push_back(mk(0, 0));
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_r = exp_q.pop_front();
      check("cycle_outputs", outs(), expv(mon_r));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit ab, pz;
    rst        = 1'b0;
    start_i    = 1'b0;
    pause_i    = 1'b0;
    abort_i    = 1'b0;
    wash_cnt_i = 3'd0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", outs(), 32'd0);

    // start presented on the very first edge after reset release
    @(negedge clk);
    rst        = 1'b1;
    start_i    = 1'b1;
    wash_cnt_i = 3'd3;
    @(posedge clk);
    #1 check("start_after_reset", outs(), expv(mk(1, 0)));
    @(negedge clk);
    start_i = 1'b0;
    k = 0;
    while (wash_pass_o != 3'd2 && k < 60) begin
      @(posedge clk);
      #1 k++;
    end
    check("reach_pass2", outs(), expv(mk(2, 2)));
    #2 rst = 1'b0;
    #1 check("async_reset", outs(), 32'd0);
    repeat (2) @(posedge clk);
    #1 check("reset_held", outs(), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'($urandom_range(0, 1));
        pause_i = 1'($urandom_range(0, 1));
        exp_q.push_back(mk(0, 0));
      end
      @(negedge clk);
      start_i    = 1'b1;
      wash_cnt_i = (t == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      abort_i    = 1'($urandom_range(0, 1));
      pause_i    = 1'($urandom_range(0, 1));
      build_plan(int'(wash_cnt_i));
      cur = plan.pop_front();
      exp_q.push_back(cur);
      while (plan.size() > 0) begin
        @(negedge clk);
        ab         = ($urandom_range(0, 39) == 0);
        pz         = ($urandom_range(0, 4) == 0);
        start_i    = 1'($urandom_range(0, 1));
        wash_cnt_i = 3'($urandom_range(0, 7));
        abort_i    = ab;
        pause_i    = pz;
        if (ab && timed(cur)) begin
          cur = mk(6, 0);
          plan.delete();
          plan.push_back(mk(0, 0));
        end else if (!(PauseOn && pz && timed(cur))) begin
          cur = plan.pop_front();
        end
        exp_q.push_back(cur);
      end
    end

    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    pause_i = 1'b0;
    @(posedge clk);
    #2 check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wash_cycle_ctrl.md
WASH_CYCLE_CTRL -- requirements
Module: wash_cycle_ctrl

Interface
REQ-001 SHALL have parameter SOAK_T, default 3: soak duration in clk cycles, legal range 1..2^CNT_W-1.
REQ-002 SHALL have parameter WASH_T, default 3: duration of one wash pass in clk cycles, same range.
REQ-003 SHALL have parameter RINSE_T, default 3: rinse duration in clk cycles, same range.
REQ-004 SHALL have parameter SPIN_T, default 3: spin duration in clk cycles, same range.
REQ-005 SHALL have parameter CNT_W, default 8: phase timer width in bits.
REQ-006 SHALL have parameter MAX_WASH, default 4: maximum wash passes, legal range 1..7.
REQ-007 SHALL have ports: clk input 1 (clock); rst input 1 (asynchronous, active-low reset).
REQ-008 SHALL have ports: start_i input 1 (coin/start request); wash_cnt_i input 3 (requested wash passes).
REQ-009 SHALL have ports: pause_i input 1 (hold the current phase); abort_i input 1 (cancel the cycle).
REQ-010 SHALL have ports: phase_o output 3 (current state code); wash_pass_o output 3 (current wash pass number, 1-based; 0 outside WASH).
REQ-011 SHALL have ports: busy_o output 1; door_lock_o output 1; done_o output 1; abort_o output 1.

Function
REQ-012 SHALL implement states IDLE=0, SOAK=1, WASH=2, RINSE=3, SPIN=4, DONE=5, ABORT=6, encoded on phase_o; code 7 SHALL recover to IDLE on the next cycle.
REQ-013 In IDLE, start_i=1 SHALL move to SOAK on the next edge and latch the pass count; start_i SHALL be ignored in every other state.
REQ-014 The latched pass count SHALL be wash_cnt_i clamped: 0 becomes 1, values above MAX_WASH become MAX_WASH.
REQ-015 Each timed state (SOAK/WASH/RINSE/SPIN) SHALL occupy exactly its *_T cycles: timer clears on state entry, increments each unpaused cycle, and the state exits on the edge where timer==*_T-1.
REQ-016 On WASH expiry, the FSM SHALL re-enter WASH with a cleared timer and wash_pass_o+1 while passes remain, else move to RINSE.
REQ-017 Transitions SHALL be SOAK->WASH, RINSE->SPIN, SPIN->DONE; DONE and ABORT SHALL each last one cycle, then move to IDLE.
REQ-018 abort_i=1 in any timed state SHALL move to ABORT on the next edge, with priority over pause and timer expiry; abort_i SHALL be ignored in IDLE/DONE/ABORT.
REQ-019 done_o SHALL be 1 exactly during the DONE cycle; abort_o SHALL be 1 exactly during the ABORT cycle; both SHALL be registered state decodes.
REQ-020 busy_o SHALL be 1 in timed states; door_lock_o SHALL be 1 in timed states and in DONE.
REQ-021 Expiry and pause in the same cycle SHALL resolve as pause: the state holds and the timer does not advance (only when pause is compiled in).
REQ-022 Timer arithmetic SHALL be CNT_W bits unsigned with no wrap; no timer value at or above *_T SHALL be reachable.

Reset
REQ-023 rst=0 SHALL asynchronously force state IDLE, timer 0, latched pass count 0, pass counter 0.
REQ-024 During reset, all outputs SHALL read 0; reset mid-cycle SHALL abandon the cycle without asserting done_o or abort_o.
REQ-025 The first edge after rst deasserts SHALL evaluate start_i normally.

Configuration
REQ-026 With macro WASH_PAUSE_EN defined, pause_i=1 in a timed state SHALL freeze the state, timer, and pass counter; outputs SHALL hold, and abort_i SHALL remain honoured.
REQ-027 Without WASH_PAUSE_EN, pause_i SHALL be ignored and no pause logic SHALL be synthesised.

Verification
REQ-028 Defaults, wash_cnt_i=1, start_i pulse at cycle 0: SOAK cycles 1-3, WASH 4-6, RINSE 7-9, SPIN 10-12, done_o=1 at cycle 13, IDLE at 14.
REQ-029 wash_cnt_i=6, MAX_WASH=4: wash_pass_o steps 1,2,3,4 every 3 cycles; WASH spans 12 cycles; done_o at cycle 22.
REQ-030 wash_cnt_i=0: exactly one wash pass; timing identical to REQ-028.
REQ-031 abort_i=1 in the 2nd SPIN cycle: abort_o=1 on the next cycle, then IDLE; done_o never asserts; abort_i in IDLE has no effect.
REQ-032 WASH_PAUSE_EN defined, pause_i high 5 cycles during RINSE timer=1: phase_o=3 and timer=1 held, done_o delayed by 5 cycles; pause_i+abort_i together -> ABORT.
REQ-033 rst pulsed low in the 2nd WASH pass: immediate IDLE, all outputs 0; a new start_i then runs a full cycle matching REQ-028.
